// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, write-back entry type and source select for the write-back arbiter.
package wb_pkg;
    localparam int DEF_A_WIDTH = 5;
    localparam int DEF_D_WIDTH = 32;

    typedef struct packed {
        logic [DEF_A_WIDTH-1:0] rd;
        logic [DEF_D_WIDTH-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_LD} wb_src_e;
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: ALU, load, issue, decode-lookup and register-file write signals of the arbiter.
interface wb_arbiter_if
    import wb_pkg::*;
#(
    parameter int A_WIDTH = DEF_A_WIDTH,
    parameter int D_WIDTH = DEF_D_WIDTH
);
    logic               alu_valid;
    logic [A_WIDTH-1:0] alu_rd;
    logic [D_WIDTH-1:0] alu_data;
    logic               alu_stall;
    logic               ld_valid;
    logic               ld_ready;
    logic [A_WIDTH-1:0] ld_rd;
    logic [D_WIDTH-1:0] ld_data;
    logic               issue_valid;
    logic [A_WIDTH-1:0] issue_rd;
    logic [A_WIDTH-1:0] A1;
    logic [A_WIDTH-1:0] A2;
    logic               busy1;
    logic               busy2;
    logic               fwd1_hit;
    logic               fwd2_hit;
    logic               WE3;
    logic [A_WIDTH-1:0] A3;
    logic [D_WIDTH-1:0] WD3;

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, issue_valid, issue_rd, A1, A2,
        output alu_stall, ld_ready, busy1, busy2, fwd1_hit, fwd2_hit, WE3, A3, WD3
    );

    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, issue_valid, issue_rd, A1, A2,
        input  alu_stall, ld_ready, busy1, busy2, fwd1_hit, fwd2_hit, WE3, A3, WD3
    );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of write-back entries with a combinational head, async active-low reset.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      CLK,
    input  logic      RST_N,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t din,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);
    localparam int PW = $clog2(DEPTH);

    wb_entry_t      mem [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [PW:0]    count;
    logic           do_push, do_pop;

    assign full    = count == (PW+1)'(DEPTH);
    assign empty   = count == '0;
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(do_push);
            rd_ptr <= rd_ptr + PW'(do_pop);
            count  <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file write-back arbiter merging ALU results with buffered load results.
// Define WB_FORWARD_EN to build the WD3 forwarding-hit comparators; otherwise the hits are tied low.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int A_WIDTH      = DEF_A_WIDTH,
    parameter int D_WIDTH      = DEF_D_WIDTH,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input logic         CLK,
    input logic         RST_N,
    wb_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    wb_entry_t             ld_entry, head;
    wb_src_e               src;
    logic                  full, empty, pop, push, starve_hit, we3_next;
    logic [CW-1:0]         starve_cnt;
    logic [2**A_WIDTH-1:0] busy, busy_next;
    logic [A_WIDTH-1:0]    a3_next;
    logic [D_WIDTH-1:0]    wd3_next;

    assign ld_entry     = '{rd: bus.ld_rd, data: bus.ld_data};
    assign src          = bus.alu_valid ? WB_ALU : !empty ? WB_LD : WB_NONE;
    assign pop          = src == WB_LD;
    assign push         = bus.ld_valid && !full;
    assign bus.ld_ready = !full;
    assign bus.busy1    = busy[bus.A1];
    assign bus.busy2    = busy[bus.A2];
    assign starve_hit   = bus.alu_valid && !empty && starve_cnt == CW'(STARVE_LIMIT - 1);

`ifdef WB_FORWARD_EN
    assign bus.fwd1_hit = bus.WE3 && bus.A3 == bus.A1 && bus.A1 != '0;
    assign bus.fwd2_hit = bus.WE3 && bus.A3 == bus.A2 && bus.A2 != '0;
`else
    assign bus.fwd1_hit = 1'b0;
    assign bus.fwd2_hit = 1'b0;
`endif

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK   (CLK),
        .RST_N (RST_N),
        .push  (push),
        .pop   (pop),
        .din   (ld_entry),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    // rd=0 entries still win arbitration (and pop) but never write
    always_comb begin
        we3_next  = src == WB_ALU ? bus.alu_rd != '0 : pop && head.rd != '0;
        a3_next   = src == WB_ALU ? bus.alu_rd : head.rd;
        wd3_next  = src == WB_ALU ? bus.alu_data : head.data;
        busy_next = busy;
        if (pop) busy_next[head.rd] = 1'b0;
        if (bus.issue_valid && bus.issue_rd != '0) busy_next[bus.issue_rd] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bus.WE3       <= 1'b0;
            bus.A3        <= '0;
            bus.WD3       <= '0;
            bus.alu_stall <= 1'b0;
            starve_cnt    <= '0;
            busy          <= '0;
        end else begin
            bus.WE3       <= we3_next;
            if (src != WB_NONE) begin
                bus.A3  <= a3_next;
                bus.WD3 <= wd3_next;
            end
            bus.alu_stall <= starve_hit;
            starve_cnt    <= (bus.alu_valid && !empty && !starve_hit) ? starve_cnt + 1'b1 : '0;
            busy          <= busy_next;
        end
    end

    a_no_alu_during_stall: assert property (@(posedge CLK) disable iff (!RST_N) !(bus.alu_stall && bus.alu_valid));
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and randomized checks of wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;
    localparam int DEPTH = 4;
    localparam int LIMIT = 3;
`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    wb_arbiter_if bus ();

    wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    // Reference model: loads wait in a queue, ALU always wins, deferrals counted per spec rules
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    ent_t        e;
    logic        m_we, m_stall, can_push;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;
    logic [31:0] m_busy;
    int          m_defer;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q.delete();
            m_we = 0; m_a3 = 0; m_wd = 0; m_stall = 0; m_busy = '0; m_defer = 0;
        end else begin
            can_push = q.size() < DEPTH;
            m_stall = 0;
            if (bus.alu_valid) begin
                m_we = bus.alu_rd != 0; m_a3 = bus.alu_rd; m_wd = bus.alu_data;
                if (q.size() > 0) begin
                    m_defer++;
                    if (m_defer == LIMIT) begin m_stall = 1; m_defer = 0; end
                end else m_defer = 0;
            end else if (q.size() > 0) begin
                e = q.pop_front();
                m_we = e.rd != 0; m_a3 = e.rd; m_wd = e.data; m_busy[e.rd] = 0; m_defer = 0;
            end else begin
                m_we = 0; m_defer = 0;
            end
            if (bus.issue_valid && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1;
            if (bus.ld_valid && can_push) q.push_back('{bus.ld_rd, bus.ld_data});
        end
    end

    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle();
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        bus.ld_valid = 0; bus.ld_rd = 0; bus.ld_data = 0;
        bus.issue_valid = 0; bus.issue_rd = 0;
    endtask

    task automatic test_reset();
        idle();
        bus.A1 = 5'd7; bus.A2 = 5'd9;
        RST_N = 0;
        repeat (3) cyc();
        RST_N = 1;
        cyc();
        checks++; if (bus.WE3 !== 1'b0) begin errors++; $display("FAIL reset_we3: got %b want 0", bus.WE3); end
        checks++; if (bus.A3 !== 5'd0) begin errors++; $display("FAIL reset_a3: got %0d want 0", bus.A3); end
        checks++; if (bus.WD3 !== 32'd0) begin errors++; $display("FAIL reset_wd3: got %h want 0", bus.WD3); end
        checks++; if (bus.alu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.alu_stall); end
        checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.ld_ready); end
        checks++; if (bus.busy1 !== 1'b0 || bus.busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b%b want 00", bus.busy1, bus.busy2); end
    endtask

    task automatic test_alu();
        bus.alu_valid = 1; bus.alu_rd = 5'd3; bus.alu_data = 32'h0000_00AA;
        cyc();
        bus.alu_valid = 0;
        checks++; if (bus.WE3 !== 1'b1 || bus.A3 !== 5'd3 || bus.WD3 !== 32'hAA) begin
            errors++; $display("FAIL alu_write: got we=%b a3=%0d wd=%h want 1/3/000000aa", bus.WE3, bus.A3, bus.WD3); end
        bus.alu_valid = 1; bus.alu_rd = 5'd0; bus.alu_data = 32'h55;
        cyc();
        bus.alu_valid = 0;
        checks++; if (bus.WE3 !== 1'b0) begin errors++; $display("FAIL alu_rd0: got we=%b want 0", bus.WE3); end
        cyc();
        checks++; if (bus.WE3 !== 1'b0) begin errors++; $display("FAIL alu_idle: got we=%b want 0", bus.WE3); end
    endtask

    task automatic test_forward();
        bus.alu_valid = 1; bus.alu_rd = 5'd5; bus.alu_data = 32'hF00D;
        cyc();
        bus.alu_valid = 0; bus.A1 = 5'd5; bus.A2 = 5'd0;
        #1;
        checks++; if (bus.fwd1_hit !== FWD) begin errors++; $display("FAIL fwd1_hit: got %b want %b", bus.fwd1_hit, FWD); end
        checks++; if (bus.fwd2_hit !== 1'b0) begin errors++; $display("FAIL fwd2_rd0: got %b want 0", bus.fwd2_hit); end
        bus.A1 = 5'd6;
        #1;
        checks++; if (bus.fwd1_hit !== 1'b0) begin errors++; $display("FAIL fwd1_miss: got %b want 0", bus.fwd1_hit); end
        cyc();
        bus.A1 = 5'd5;
        #1;
        checks++; if (bus.fwd1_hit !== 1'b0) begin errors++; $display("FAIL fwd1_no_we: got %b want 0", bus.fwd1_hit); end
    endtask

    task automatic test_load_busy();
        bus.A1 = 5'd7;
        #1;
        checks++; if (bus.busy1 !== 1'b0) begin errors++; $display("FAIL ld_busy_pre: got %b want 0", bus.busy1); end
        bus.issue_valid = 1; bus.issue_rd = 5'd7;
        cyc();
        bus.issue_valid = 0;
        checks++; if (bus.busy1 !== 1'b1) begin errors++; $display("FAIL ld_busy_set: got %b want 1", bus.busy1); end
        bus.ld_valid = 1; bus.ld_rd = 5'd7; bus.ld_data = 32'h1234;
        cyc();
        bus.ld_valid = 0;
        checks++; if (bus.busy1 !== 1'b1 || bus.WE3 !== 1'b0) begin
            errors++; $display("FAIL ld_n1: got busy=%b we=%b want 1/0", bus.busy1, bus.WE3); end
        cyc();
        checks++; if (bus.WE3 !== 1'b1 || bus.A3 !== 5'd7 || bus.WD3 !== 32'h1234) begin
            errors++; $display("FAIL ld_write: got we=%b a3=%0d wd=%h want 1/7/00001234", bus.WE3, bus.A3, bus.WD3); end
        checks++; if (bus.busy1 !== 1'b0) begin errors++; $display("FAIL ld_busy_clr: got %b want 0", bus.busy1); end
    endtask

    task automatic test_starve();
        logic [4:0]  rds [5];
        logic [31:0] dat [5];
        int sent = 0, got = 0, stalls = 0, first_stall = -1, n;
        bit saw_full = 0, prev_stall = 0, dbl = 0, hs;
        for (int k = 0; k < 5; k++) begin rds[k] = 5'(10 + k); dat[k] = $urandom; end
        bus.alu_rd = 5'd20; bus.alu_data = 32'hA1A1_0000;
        for (n = 0; n < 80 && got < 5; n++) begin
            bus.alu_valid = !bus.alu_stall;
            bus.ld_valid = sent < 5;
            if (sent < 5) begin bus.ld_rd = rds[sent]; bus.ld_data = dat[sent]; end
            if (!bus.ld_ready) saw_full = 1;
            hs = bus.ld_valid && bus.ld_ready;
            cyc();
            if (hs) sent++;
            if (bus.alu_stall) begin
                stalls++;
                if (first_stall < 0) first_stall = n + 1;
                if (prev_stall) dbl = 1;
            end
            prev_stall = bus.alu_stall;
            if (bus.WE3 && bus.A3 != 5'd20) begin
                checks++;
                if (got >= 5) begin errors++; $display("FAIL starve_extra: a3=%0d", bus.A3); end
                else if (bus.A3 !== rds[got] || bus.WD3 !== dat[got]) begin
                    errors++; $display("FAIL starve_order #%0d: got %0d/%h want %0d/%h", got, bus.A3, bus.WD3, rds[got], dat[got]); end
                got++;
            end
        end
        idle();
        checks++; if (got != 5) begin errors++; $display("FAIL starve_drain: got %0d writes want 5", got); end
        checks++; if (first_stall != 4) begin errors++; $display("FAIL starve_first: got cycle %0d want 4", first_stall); end
        checks++; if (stalls != 5) begin errors++; $display("FAIL starve_count: got %0d want 5", stalls); end
        checks++; if (!saw_full) begin errors++; $display("FAIL starve_ready: got ld_ready never low want low when 4 buffered"); end
        checks++; if (dbl) begin errors++; $display("FAIL starve_pulse: got stall high 2 cycles want 1"); end
        cyc();
    endtask

    task automatic test_busy_set_wins();
        bus.A1 = 5'd9;
        bus.issue_valid = 1; bus.issue_rd = 5'd9;
        cyc();
        bus.issue_valid = 0;
        bus.ld_valid = 1; bus.ld_rd = 5'd9; bus.ld_data = 32'h99;
        cyc();
        bus.ld_valid = 0;
        bus.issue_valid = 1; bus.issue_rd = 5'd9;
        cyc();
        bus.issue_valid = 0;
        checks++; if (bus.WE3 !== 1'b1 || bus.A3 !== 5'd9) begin
            errors++; $display("FAIL setwin_write: got we=%b a3=%0d want 1/9", bus.WE3, bus.A3); end
        checks++; if (bus.busy1 !== 1'b1) begin errors++; $display("FAIL setwin_busy: got %b want 1", bus.busy1); end
        cyc();
        checks++; if (bus.busy1 !== 1'b1) begin errors++; $display("FAIL setwin_hold: got %b want 1", bus.busy1); end
    endtask

    task automatic test_async_reset();
        bus.A1 = 5'd4;
        bus.issue_valid = 1; bus.issue_rd = 5'd4;
        cyc();
        bus.issue_valid = 0;
        bus.alu_valid = 1; bus.alu_rd = 5'd2; bus.alu_data = 32'h2;
        bus.ld_valid = 1; bus.ld_rd = 5'd4; bus.ld_data = 32'h4444;
        cyc();
        cyc();
        checks++; if (bus.busy1 !== 1'b1) begin errors++; $display("FAIL arst_pre_busy: got %b want 1", bus.busy1); end
        #2 RST_N = 0;
        idle();
        #1;
        checks++; if (bus.ld_ready !== 1'b1 || bus.busy1 !== 1'b0 || bus.WE3 !== 1'b0 || bus.alu_stall !== 1'b0) begin
            errors++; $display("FAIL arst_now: got ready=%b busy=%b we=%b stall=%b want 1/0/0/0", bus.ld_ready, bus.busy1, bus.WE3, bus.alu_stall); end
        @(negedge CLK);
        RST_N = 1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            checks++; if (bus.WE3 !== 1'b0) begin errors++; $display("FAIL arst_discard c%0d: got we=%b want 0", k, bus.WE3); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            checks++; if (bus.WE3 !== m_we) begin errors++; $display("FAIL rnd_we3 @%0d: got %b want %b", i, bus.WE3, m_we); end
            if (m_we) begin
                checks++; if (bus.A3 !== m_a3 || bus.WD3 !== m_wd) begin
                    errors++; $display("FAIL rnd_wdata @%0d: got %0d/%h want %0d/%h", i, bus.A3, bus.WD3, m_a3, m_wd); end
            end
            checks++; if (bus.alu_stall !== m_stall) begin errors++; $display("FAIL rnd_stall @%0d: got %b want %b", i, bus.alu_stall, m_stall); end
            checks++; if (bus.ld_ready !== (q.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready @%0d: got %b want %b", i, bus.ld_ready, q.size() < DEPTH); end
            checks++; if (bus.busy1 !== m_busy[bus.A1] || bus.busy2 !== m_busy[bus.A2]) begin
                errors++; $display("FAIL rnd_busy @%0d: got %b%b want %b%b", i, bus.busy1, bus.busy2, m_busy[bus.A1], m_busy[bus.A2]); end
            checks++; if (bus.fwd1_hit !== (FWD && m_we && m_a3 == bus.A1 && bus.A1 != 0)) begin
                errors++; $display("FAIL rnd_fwd1 @%0d: got %b", i, bus.fwd1_hit); end
            bus.alu_valid = !bus.alu_stall && ($urandom_range(0, 9) < 4);
            bus.alu_rd = 5'($urandom_range(0, 31)); bus.alu_data = $urandom;
            bus.ld_valid = $urandom_range(0, 1) == 1;
            bus.ld_rd = 5'($urandom_range(0, 31)); bus.ld_data = $urandom;
            bus.issue_valid = $urandom_range(0, 3) == 0;
            bus.issue_rd = 5'($urandom_range(0, 31));
            bus.A1 = 5'($urandom_range(0, 31)); bus.A2 = 5'($urandom_range(0, 31));
            cyc();
        end
        idle();
    endtask

    initial begin
        idle();
        bus.A1 = 0; bus.A2 = 0;
        test_reset();
        test_alu();
        test_forward();
        test_load_busy();
        test_starve();
        test_busy_set_wins();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
